// File: rtl/regfile_ecall_unit.sv
// Register file with a small ecall service FSM: print, read, halt and test-case load.
// a7 selects the syscall, a0 carries its argument/result; stall holds the CPU during handshakes.
module regfile_ecall_unit #(
    parameter int              XLEN    = 32,
    parameter int              NREG    = 32,
    parameter int              SYS_IDX = 17,
    parameter logic [XLEN-1:0] SP_INIT = 'h7fff,
    parameter logic [XLEN-1:0] GP_INIT = 'h1000,
    parameter bit              BYPASS  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREG)-1:0]  rs1,
    input  logic [$clog2(NREG)-1:0]  rs2,
    input  logic [$clog2(NREG)-1:0]  rd,
    input  logic [XLEN-1:0]          write_data,
    input  logic                     reg_write,
    input  logic                     ecall,
    input  logic [XLEN-1:0]          test_case,
    input  logic [XLEN-1:0]          io_in_data,
    input  logic                     io_in_valid,
    output logic                     io_in_ready,
    output logic [XLEN-1:0]          io_out_data,
    output logic                     io_out_valid,
    input  logic                     io_out_ready,
    output logic [XLEN-1:0]          read_data1,
    output logic [XLEN-1:0]          read_data2,
    output logic                     stall,
    output logic                     halted,
    output logic [7:0]               led_out
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, PRINT, READ, HALT} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] a0;
    logic [XLEN-1:0] a7;
    logic            sys_print;
    logic            sys_read;
    logic            sys_exit;
    logic            sys_test;
    logic            do_test;
    logic            print_done;
    logic            read_done;
    logic            wr_en;
    logic            led_test;
    logic            led_read;

    assign a0 = regs[10];
    assign a7 = regs[SYS_IDX];

    assign sys_print = (a7 == XLEN'(1));
    assign sys_read  = (a7 == XLEN'(5));
    assign sys_exit  = (a7 == XLEN'(10));
    assign sys_test  = (a7 == XLEN'(11));

    assign do_test    = (state_q == IDLE) && ecall && sys_test;
    assign print_done = (state_q == PRINT) && io_out_ready;
    assign read_done  = (state_q == READ) && io_in_valid;
    assign wr_en      = reg_write && (rd != '0) && (state_q == IDLE) && !ecall;

    // Stall drops in the completion cycle so the CPU retires the ecall on the
    // same edge the FSM returns to IDLE and the ecall is never decoded twice.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ecall) begin
                    if (sys_print) begin
                        state_d = PRINT;
                        stall   = 1'b1;
                    end else if (sys_read) begin
                        state_d = READ;
                        stall   = 1'b1;
                    end else if (sys_exit) begin
                        state_d = HALT;
                        stall   = 1'b1;
                    end
                end
            end
            PRINT: begin
                stall = !io_out_ready;
                if (io_out_ready) state_d = IDLE;
            end
            READ: begin
                stall = !io_in_valid;
                if (io_in_valid) state_d = IDLE;
            end
            HALT: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            io_out_valid <= 1'b0;
            io_out_data  <= '0;
            io_in_ready  <= 1'b0;
            halted       <= 1'b0;
            led_test     <= 1'b0;
            led_read     <= 1'b0;
        end else begin
            state_q  <= state_d;
            led_test <= do_test;
            led_read <= read_done;
            if (state_q == IDLE && state_d == PRINT) begin
                io_out_valid <= 1'b1;
                io_out_data  <= a0;
            end else if (print_done) begin
                io_out_valid <= 1'b0;
            end
            if (state_q == IDLE && state_d == READ) begin
                io_in_ready <= 1'b1;
            end else if (read_done) begin
                io_in_ready <= 1'b0;
            end
            if (state_q == IDLE && state_d == HALT) begin
                halted <= 1'b1;
            end
        end
    end

    // a0 is written by the test-case load and by input completion; neither can
    // coincide with a CPU write because those only happen in IDLE without ecall.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                if (i == 2)
                    regs[i] <= SP_INIT;
                else if (i == 3)
                    regs[i] <= GP_INIT;
                else
                    regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                regs[rd] <= write_data;
            end
            if (do_test) begin
                regs[10] <= test_case;
            end else if (read_done) begin
                regs[10] <= io_in_data;
            end
        end
    end

    always_comb begin
        read_data1 = regs[rs1];
        if (rs1 == AW'(0))
            read_data1 = '0;
        else if (BYPASS && reg_write && rd != AW'(0) && rd == rs1)
            read_data1 = write_data;
    end

    always_comb begin
        read_data2 = regs[rs2];
        if (rs2 == AW'(0))
            read_data2 = '0;
        else if (BYPASS && reg_write && rd != AW'(0) && rd == rs2)
            read_data2 = write_data;
    end

    assign led_out = {led_read, 5'b0, led_test, halted};

endmodule

// File: tb/tb_regfile_ecall_unit.sv
// Directed self-checking bench for regfile_ecall_unit: register file, bypass,
// each syscall handshake, halt persistence and reset aborting a transaction.
module tb_regfile_ecall_unit;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        reg_write;
    logic        ecall;
    logic [31:0] test_case;
    logic [31:0] io_in_data;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_out_data;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        stall;
    logic        halted;
    logic [7:0]  led_out;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_ecall_unit dut (
        .clk          (clk),
        .reset        (reset),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .write_data   (write_data),
        .reg_write    (reg_write),
        .ecall        (ecall),
        .test_case    (test_case),
        .io_in_data   (io_in_data),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_out_data  (io_out_data),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .read_data1   (read_data1),
        .read_data2   (read_data2),
        .stall        (stall),
        .halted       (halted),
        .led_out      (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Writes one register through the CPU port; returns at the following negedge.
    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] value);
        rd         = addr;
        write_data = value;
        reg_write  = 1'b1;
        @(negedge clk);
        reg_write  = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; write_data = '0;
        reg_write = 1'b0; ecall = 1'b0; test_case = '0; io_in_data = '0;
        io_in_valid = 1'b0; io_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rs1 = 5'd2; rs2 = 5'd3;
        #1;
        checkOutput("reset_x2", read_data1, 32'h7fff);
        checkOutput("reset_x3", read_data2, 32'h1000);
        checkOutput("reset_halted", {31'b0, halted}, 32'd0);
        checkOutput("reset_led", {24'b0, led_out}, 32'd0);
        checkOutput("reset_out_valid", {31'b0, io_out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'b0, io_in_ready}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);

        // Bypass on the write cycle, stored value afterwards, x0 stays zero
        @(negedge clk);
        rs1 = 5'd5; rs2 = 5'd5; rd = 5'd5; write_data = 32'hDEADBEEF; reg_write = 1'b1;
        #1;
        checkOutput("bypass_rs1", read_data1, 32'hDEADBEEF);
        checkOutput("bypass_rs2", read_data2, 32'hDEADBEEF);
        @(negedge clk);
        reg_write = 1'b0; write_data = 32'h0;
        #1;
        checkOutput("stored_x5", read_data1, 32'hDEADBEEF);
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; write_data = 32'd1; reg_write = 1'b1;
        #1;
        checkOutput("x0_bypass", read_data1, 32'd0);
        @(negedge clk);
        reg_write = 1'b0;
        #1;
        checkOutput("x0_stored", read_data2, 32'd0);

        // Print syscall: sink stalls 3 cycles
        applyStimulus(5'd17, 32'd1);
        applyStimulus(5'd10, 32'd42);
        ecall = 1'b1;
        #1;
        checkOutput("print_decode_stall", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("print_wait_valid", {31'b0, io_out_valid}, 32'd1);
            checkOutput("print_wait_data", io_out_data, 32'd42);
            checkOutput("print_wait_stall", {31'b0, stall}, 32'd1);
        end
        @(negedge clk);
        io_out_ready = 1'b1;
        #1;
        checkOutput("print_done_valid", {31'b0, io_out_valid}, 32'd1);
        checkOutput("print_done_data", io_out_data, 32'd42);
        checkOutput("print_done_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        ecall = 1'b0; io_out_ready = 1'b0;
        #1;
        checkOutput("print_after_valid", {31'b0, io_out_valid}, 32'd0);
        checkOutput("print_after_stall", {31'b0, stall}, 32'd0);

        // Read syscall: source arrives after 2 cycles; early valid in IDLE ignored
        io_in_valid = 1'b1; io_in_data = 32'h99;
        @(negedge clk);
        io_in_valid = 1'b0;
        rs1 = 5'd10;
        #1;
        checkOutput("idle_input_ignored", read_data1, 32'd42);
        applyStimulus(5'd17, 32'd5);
        ecall = 1'b1;
        #1;
        checkOutput("read_decode_stall", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checkOutput("read_wait_ready", {31'b0, io_in_ready}, 32'd1);
            checkOutput("read_wait_stall", {31'b0, stall}, 32'd1);
        end
        @(negedge clk);
        io_in_valid = 1'b1; io_in_data = 32'h55;
        #1;
        checkOutput("read_done_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        ecall = 1'b0; io_in_valid = 1'b0;
        #1;
        checkOutput("read_a0", read_data1, 32'h55);
        checkOutput("read_led7", {24'b0, led_out}, 32'h80);
        checkOutput("read_ready_low", {31'b0, io_in_ready}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("read_led7_pulse_end", {24'b0, led_out}, 32'h00);

        // Test-case load: no stall, one-cycle LED pulse
        applyStimulus(5'd17, 32'd11);
        test_case = 32'd7; ecall = 1'b1;
        #1;
        checkOutput("test_no_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        ecall = 1'b0;
        #1;
        checkOutput("test_a0", read_data1, 32'd7);
        checkOutput("test_led1", {24'b0, led_out}, 32'h02);
        @(negedge clk);
        #1;
        checkOutput("test_led1_pulse_end", {24'b0, led_out}, 32'h00);

        // Unknown syscall with a simultaneous write: nothing happens
        applyStimulus(5'd17, 32'd3);
        ecall = 1'b1; rd = 5'd6; write_data = 32'h1234; reg_write = 1'b1;
        #1;
        checkOutput("unknown_no_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        ecall = 1'b0; reg_write = 1'b0; rs2 = 5'd6;
        #1;
        checkOutput("unknown_no_write", read_data2, 32'd0);
        checkOutput("unknown_still_idle", {31'b0, stall}, 32'd0);

        // Reset in the middle of a read aborts it without touching a0
        applyStimulus(5'd17, 32'd5);
        ecall = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("abort_ready_before", {31'b0, io_in_ready}, 32'd1);
        reset = 1'b1; ecall = 1'b0; io_in_valid = 1'b1; io_in_data = 32'hAA;
        @(negedge clk);
        reset = 1'b0; io_in_valid = 1'b0; rs1 = 5'd10; rs2 = 5'd17;
        #1;
        checkOutput("abort_ready", {31'b0, io_in_ready}, 32'd0);
        checkOutput("abort_a0", read_data1, 32'd0);
        checkOutput("abort_a7", read_data2, 32'd0);
        checkOutput("abort_idle_stall", {31'b0, stall}, 32'd0);

        // Halt persists, blocks writes, and only reset clears it
        applyStimulus(5'd17, 32'd10);
        ecall = 1'b1;
        #1;
        checkOutput("halt_decode_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        rd = 5'd5; write_data = 32'h77; reg_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("halt_halted", {31'b0, halted}, 32'd1);
            checkOutput("halt_led0", {24'b0, led_out}, 32'h01);
            checkOutput("halt_stall", {31'b0, stall}, 32'd1);
        end
        reg_write = 1'b0; rs1 = 5'd5;
        #1;
        checkOutput("halt_no_write", read_data1, 32'd0);
        reset = 1'b1; ecall = 1'b0;
        @(negedge clk);
        reset = 1'b0; rs1 = 5'd2; rs2 = 5'd3;
        #1;
        checkOutput("unhalt_halted", {31'b0, halted}, 32'd0);
        checkOutput("unhalt_led", {24'b0, led_out}, 32'd0);
        checkOutput("unhalt_x2", read_data1, 32'h7fff);
        checkOutput("unhalt_x3", read_data2, 32'h1000);
        checkOutput("unhalt_stall", {31'b0, stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
